// File: rtl/string_hw_n.sv
// Sequential string engine: compare, case conversion, reverse and character search,
// one character per clock on operands latched at start.
module string_hw_n #(
    parameter int MAXLEN = 16,
    parameter int LENW   = $clog2(MAXLEN + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       go,
    input  logic [2:0]                 index,
    input  logic [0:MAXLEN-1][7:0]     A,
    input  logic [0:MAXLEN-1][7:0]     B,
    input  logic [LENW-1:0]            lengthA,
    input  logic [LENW-1:0]            lengthB,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [0:MAXLEN-1][7:0]     result
);
    localparam int RW = MAXLEN * 8;
    localparam int IW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;

    localparam logic [2:0] OP_CMP  = 3'd0;
    localparam logic [2:0] OP_UP   = 3'd1;
    localparam logic [2:0] OP_LO   = 3'd2;
    localparam logic [2:0] OP_REV  = 3'd3;
    localparam logic [2:0] OP_FIND = 3'd4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                   state_q;
    logic [2:0]               op_q;
    logic [0:MAXLEN-1][7:0]   a_q, b_q, res_q;
    logic [LENW-1:0]          lenA_q, lenB_q, i_q;
    logic                     stop_q, errp_q, busy_q, done_q, err_q;

    logic [IW-1:0]            idx, ridx;
    logic [7:0]               ch, rch, up, lo;
    logic                     illegal, lens_ne, stop;

    function automatic logic [LENW-1:0] clamp(input logic [LENW-1:0] l);
        return (l > LENW'(MAXLEN)) ? LENW'(MAXLEN) : l;
    endfunction

    always_comb begin
        idx     = IW'(i_q);
        ridx    = IW'(lenA_q - i_q - LENW'(1));
        ch      = a_q[idx];
        rch     = a_q[ridx];
        up      = (ch >= 8'h61 && ch <= 8'h7a) ? ch - 8'h20 : ch;
        lo      = (ch >= 8'h41 && ch <= 8'h5a) ? ch + 8'h20 : ch;
        illegal = (op_q > OP_FIND);
        lens_ne = (lenA_q != lenB_q);
        // stop_q marks an early terminator (mismatch or match) seen last cycle
        stop    = stop_q || (i_q == lenA_q) || illegal || (op_q == OP_CMP && lens_ne);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            lenA_q  <= '0;
            lenB_q  <= '0;
            i_q     <= '0;
            stop_q  <= 1'b0;
            errp_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (go) begin
                    op_q    <= index;
                    a_q     <= A;
                    b_q     <= B;
                    lenA_q  <= clamp(lengthA);
                    lenB_q  <= clamp(lengthB);
                    res_q   <= '0;
                    i_q     <= '0;
                    stop_q  <= 1'b0;
                    errp_q  <= (index > OP_FIND) || (lengthA > LENW'(MAXLEN)) ||
                               (index == OP_CMP && lengthB > LENW'(MAXLEN));
                    busy_q  <= 1'b1;
                    state_q <= RUN;
                end
                RUN: if (stop) begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    err_q   <= errp_q;
                    if (!stop_q && !illegal) begin
                        if (op_q == OP_CMP && !lens_ne) res_q <= RW'(1);
                        if (op_q == OP_FIND)            res_q <= '1;
                    end
                end else begin
                    i_q <= i_q + LENW'(1);
                    case (op_q)
                        OP_CMP:  if (ch != b_q[idx]) stop_q <= 1'b1;
                        OP_UP:   res_q[idx] <= up;
                        OP_LO:   res_q[idx] <= lo;
                        OP_REV:  res_q[idx] <= rch;
                        OP_FIND: if (ch == b_q[0]) begin
                            res_q  <= RW'(i_q);
                            stop_q <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                DONE: if (!go) begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign result = res_q;
endmodule
